// File: rtl/apb_slave_regfile.sv
// APB completer with a word-addressed register file and a fixed number of wait states.
// Register 0 is a read-only ID word; indices at or above NUM_REGS read as zero and drop writes.
module apb_slave_regfile #(
  parameter int                   ADDRWIDTH   = 8,
  parameter int                   DATAWIDTH   = 32,
  parameter int                   NUM_REGS    = 16,
  parameter int                   WAIT_CYCLES = 0,
  parameter logic [DATAWIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDRWIDTH-1:0] paddr,
  input  logic                 pwrite,
  input  logic                 psel,
  input  logic                 penable,
  input  logic [DATAWIDTH-1:0] pwdata,
  output logic [DATAWIDTH-1:0] prdata,
  output logic                 pready
);

  localparam int IDXW = ADDRWIDTH - 2;

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  state_t                        state_reg;
  logic [IDXW-1:0]               idx_reg;
  logic                          pwrite_reg;
  logic [DATAWIDTH-1:0]          wdata_reg;
  logic [3:0]                    cnt_reg;
  logic [NUM_REGS*DATAWIDTH-1:0] file_flat;
  logic [IDXW-1:0]               rd_idx;
  logic [DATAWIDTH-1:0]          rd_data;
  logic                          access;
  logic                          commit;
  logic                          unused_addr_lsbs;

  assign unused_addr_lsbs = ^paddr[1:0];
  assign access = psel & penable;
  assign commit = (state_reg == READY) & access & pwrite_reg;

  // Slot 0 is the constant ID word; the rest are writable storage.
  assign file_flat[DATAWIDTH-1:0] = ID_VALUE;
  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    logic [DATAWIDTH-1:0] q_reg;
    always_ff @(posedge clk) begin
      if (rst) begin
        q_reg <= '0;
      end else if (commit && idx_reg == IDXW'(gi)) begin
        q_reg <= wdata_reg;
      end
    end
    assign file_flat[gi*DATAWIDTH +: DATAWIDTH] = q_reg;
  end

  // In IDLE the zero-wait path jumps straight to READY, so it must look up the live address.
  assign rd_idx = (state_reg == IDLE) ? paddr[ADDRWIDTH-1:2] : idx_reg;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDXW'(i)) rd_data = file_flat[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      pready     <= 1'b0;
      prdata     <= '0;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      pwrite_reg <= 1'b0;
      wdata_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (psel && !penable) begin
            idx_reg    <= paddr[ADDRWIDTH-1:2];
            pwrite_reg <= pwrite;
            wdata_reg  <= pwdata;
            cnt_reg    <= 4'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state_reg <= READY;
              pready    <= 1'b1;
              prdata    <= pwrite ? '0 : rd_data;
            end else begin
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            state_reg <= IDLE;
            pready    <= 1'b0;
            prdata    <= '0;
          end else if (penable) begin
            cnt_reg <= cnt_reg - 4'd1;
            if (cnt_reg == 4'd1) begin
              state_reg <= READY;
              pready    <= 1'b1;
              prdata    <= pwrite_reg ? '0 : rd_data;
            end
          end
        end
        READY: begin
          if (!psel || penable) begin
            state_reg <= IDLE;
            pready    <= 1'b0;
            prdata    <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          pready    <= 1'b0;
          prdata    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: three completers (0, 2 and 3 wait states) driven by an APB master task,
// checked every cycle against a transaction-level model of latency and register contents.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  paddr   [3];
  logic        pwrite  [3];
  logic        psel    [3];
  logic        penable [3];
  logic [31:0] pwdata  [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    apb_slave_regfile #(.WAIT_CYCLES(gi == 0 ? 0 : (gi == 1 ? 2 : 3))) u_dut (
      .clk    (clk),
      .rst    (rst),
      .paddr  (paddr[gi]),
      .pwrite (pwrite[gi]),
      .psel   (psel[gi]),
      .penable(penable[gi]),
      .pwdata (pwdata[gi]),
      .prdata (prdata[gi]),
      .pready (pready[gi])
    );
  end

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  logic        exp_rdy [3];
  logic [31:0] exp_dat [3];
  logic [31:0] mem [3][16];

  function automatic int wc_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  function automatic logic [31:0] model_rd(input int k, input int idx);
    if (idx == 0) return ID;
    if (idx >= 16) return 32'h0;
    return mem[k][idx];
  endfunction

  task automatic model_wr(input int k, input int idx, input logic [31:0] d);
    if (idx != 0 && idx < 16) mem[k][idx] = d;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) mem[k][i] = 32'h0;
  endtask

  task automatic idle_exp();
    for (int k = 0; k < 3; k++) begin
      exp_rdy[k] = 1'b0;
      exp_dat[k] = 32'h0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // One APB transfer on DUT k; starts just after a clock edge (the setup cycle) and returns
  // just after the edge that ends it. abort_at>0 drops psel in that access cycle.
  task automatic xfer(input int k, input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                      input int abort_at, output logic [31:0] rd, output int nacc);
    int  w;
    int  idx;
    bit  done;
    w    = wc_of(k);
    idx  = int'(addr[7:2]);
    rd   = 32'h0;
    nacc = 0;
    done = 1'b0;
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = wd;
    idle_exp();
    for (int n = 1; n <= 20 && !done; n++) begin
      @(posedge clk); #1;
      paddr[k]   = 8'($urandom);
      pwdata[k]  = $urandom;
      exp_rdy[k] = (n > w);
      exp_dat[k] = (n > w && !wr) ? model_rd(k, idx) : 32'h0;
      if (n == abort_at) begin
        psel[k] = 1'b0; penable[k] = 1'b0;
        done = 1'b1;
      end else begin
        penable[k] = 1'b1;
        @(negedge clk);
        if (pready[k] === 1'b1) begin
          rd   = prdata[k];
          nacc = n;
          done = 1'b1;
          if (wr) model_wr(k, idx, wd);
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout dut%0d addr=%h got no pready want pready within 20 cycles", k, addr);
    end
    @(posedge clk); #1;
    psel[k] = 1'b0; penable[k] = 1'b0;
    idle_exp();
  endtask

  initial begin
    logic [31:0] rd;
    int          n;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      paddr[k] = 8'h0; pwrite[k] = 1'b0; psel[k] = 1'b0; penable[k] = 1'b0; pwdata[k] = 32'h0;
    end
    idle_exp();
    model_reset();

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          for (int k = 0; k < 3; k++) begin
            chk($sformatf("pready_dut%0d", k), 32'(pready[k]), 32'(exp_rdy[k]));
            chk($sformatf("prdata_dut%0d", k), prdata[k], exp_dat[k]);
          end
        end
      end
    join_none

    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Zero wait states: write then read back, completing in the first access cycle.
    xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 0, rd, n);
    xfer(0, 1'b0, 8'h04, 32'h0, 0, rd, n);
    chk("w0_read04", rd, 32'hDEADBEEF);
    chk("w0_latency", 32'(n), 32'd1);

    // Three wait states: ID read completes on the 4th access cycle.
    xfer(2, 1'b0, 8'h00, 32'h0, 0, rd, n);
    chk("w3_read_id", rd, ID);
    chk("w3_latency", 32'(n), 32'd4);

    // Read-only ID and out-of-range index.
    xfer(1, 1'b1, 8'h00, 32'h0000_1234, 0, rd, n);
    xfer(1, 1'b0, 8'h00, 32'h0, 0, rd, n);
    chk("id_readonly", rd, ID);
    xfer(1, 1'b1, 8'h80, 32'h5555_AAAA, 0, rd, n);
    xfer(1, 1'b0, 8'h80, 32'h0, 0, rd, n);
    chk("out_of_range", rd, 32'h0);

    // Back-to-back transfers with no idle gap.
    xfer(0, 1'b1, 8'h08, 32'h1111_0008, 0, rd, n);
    xfer(0, 1'b1, 8'h0C, 32'h2222_000C, 0, rd, n);
    xfer(0, 1'b1, 8'h10, 32'h3333_0010, 0, rd, n);
    xfer(0, 1'b0, 8'h08, 32'h0, 0, rd, n);
    chk("b2b_read08", rd, 32'h1111_0008);
    xfer(0, 1'b0, 8'h0C, 32'h0, 0, rd, n);
    chk("b2b_read0C", rd, 32'h2222_000C);
    xfer(0, 1'b0, 8'h10, 32'h0, 0, rd, n);
    chk("b2b_read10", rd, 32'h3333_0010);

    // Abort mid-WAIT: the write must not land.
    xfer(1, 1'b1, 8'h14, 32'hBAD0_0014, 2, rd, n);
    xfer(1, 1'b0, 8'h14, 32'h0, 0, rd, n);
    chk("abort_read14", rd, 32'h0);

    // Reset during a WAIT-state write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h18; pwdata[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel[1] = 1'b0; penable[1] = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_pready", 32'(pready[1]), 32'd0);
    chk("rst_prdata", prdata[1], 32'h0);
    @(posedge clk); #1;
    xfer(1, 1'b0, 8'h18, 32'h0, 0, rd, n);
    chk("rst_read18", rd, 32'h0);
    xfer(0, 1'b0, 8'h04, 32'h0, 0, rd, n);
    chk("rst_clears04", rd, 32'h0);

    // Randomized traffic, with occasional aborts, idle gaps and stray access-phase strobes.
    for (int t = 0; t < 300; t++) begin
      int          k;
      int          w;
      int          ab;
      bit          wr;
      logic [7:0]  addr;
      k    = $urandom_range(0, 2);
      w    = wc_of(k);
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 63)) : 8'($urandom);
      ab   = (w > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(1, w) : 0;
      xfer(k, wr, addr, $urandom, ab, rd, n);
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 3) == 0) begin
          psel[k] = 1'b1; penable[k] = 1'b1;
        end
        @(posedge clk); #1;
        psel[k] = 1'b0; penable[k] = 1'b0;
      end
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
